// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package mbist_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
  typedef enum logic {OP_W = 1'b0, OP_R = 1'b1} op_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ctrl_state_e;

  // Bit i describes element Mi: 1 = ascending / background all-ones.
  localparam logic [7:0] ELEM_UP  = 8'b0010_0111;
  localparam logic [7:0] ELEM_RBG = 8'b0001_0100;
  localparam logic [7:0] ELEM_WBG = 8'b0000_1010;

  typedef struct packed {
    ctrl_state_e state;
    march_elem_e elem;
    op_e         op;
    logic        first;
  } mbist_dbg_t;

  function automatic march_elem_e next_elem(march_elem_e e);
    return march_elem_e'(e + 3'd1);
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port SRAM bus: address/data/we out, registered read data back.
// No handshake: one op per cycle, ramout is valid the cycle after its address.
interface mbist_march_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramin;
  logic              we;
  logic [DATA_W-1:0] ramout;

  modport master (output ramaddr, output ramin, output we, input ramout);
  modport slave  (input ramaddr, input ramin, input we, output ramout);
endinterface

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter with first/last flags for the current direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_up,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  logic up;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      up   <= 1'b1;
    end else if (load_up) begin
      addr <= '0;
      up   <= 1'b1;
    end else if (load_down) begin
      addr <= '1;
      up   <= 1'b0;
    end else if (step) begin
      addr <= up ? addr + 1'b1 : addr - 1'b1;
    end
  end

  assign first = up ? (addr == '0) : (addr == '1);
  assign last  = up ? (addr == '1) : (addr == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sequences the SRAM through M0..M5, checks reads,
// records the first failure and a saturating error count; idle = functional pass-through.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    func_addr,
  input  logic [DATA_W-1:0]    func_wdata,
  input  logic                 func_we,
  mbist_march_ctrl_if.master   sram,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [2:0]           fail_elem,
  output logic [DATA_W-1:0]    fail_rdata,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output mbist_dbg_t           dbg
);

  ctrl_state_e       state;
  march_elem_e       elem;
  march_elem_e       elem_nx;
  op_e               phase;
  op_e               op;
  logic              start_q;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_first;
  logic              gen_last;
  logic              run, go, adv, elem_end;
  logic              load_up, load_down, step;
  logic [DATA_W-1:0] seq_wdata;

  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  march_elem_e       cmp_elem;
  logic              mismatch;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_up   (load_up),
    .load_down (load_down),
    .step      (step),
    .addr      (gen_addr),
    .first     (gen_first),
    .last      (gen_last)
  );

  // M0 is write-only and M5 read-only; M1-M4 alternate read then write per address.
  always_comb begin
    run     = (state == RUN);
    go      = start_q && ((state == IDLE) || (state == DONE));
    elem_nx = next_elem(elem);
    op      = phase;
    if (elem == M0) op = OP_W;
    else if (elem == M5) op = OP_R;
    adv       = run && ((op == OP_W) || (elem == M5));
    elem_end  = adv && gen_last;
    load_up   = go || (elem_end && (elem != M5) && ELEM_UP[elem_nx]);
    load_down = elem_end && (elem != M5) && !ELEM_UP[elem_nx];
    step      = adv && !gen_last;
    seq_wdata = {DATA_W{ELEM_WBG[elem]}};
    mismatch  = cmp_vld && (sram.ramout != cmp_exp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      elem       <= M0;
      phase      <= OP_R;
      start_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_rdata <= '0;
      err_cnt    <= '0;
      cmp_vld    <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
      cmp_elem   <= M0;
    end else begin
      start_q  <= start && ((state == IDLE) || (state == DONE)) && !start_q;
      cmp_vld  <= run && (op == OP_R);
      cmp_exp  <= {DATA_W{ELEM_RBG[elem]}};
      cmp_addr <= gen_addr;
      cmp_elem <= elem;

      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!fail) begin
          fail       <= 1'b1;
          fail_addr  <= cmp_addr;
          fail_elem  <= cmp_elem;
          fail_rdata <= sram.ramout;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (go) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_rdata <= '0;
            err_cnt    <= '0;
            elem       <= M0;
            phase      <= OP_R;
          end
        end
        RUN: begin
          if ((elem != M0) && (elem != M5)) phase <= (phase == OP_R) ? OP_W : OP_R;
          if (elem_end) begin
            if (elem == M5) state <= DRAIN;
            else elem <= elem_nx;
          end
        end
        DRAIN: begin
          // The last M5 read is compared this cycle, so fail/err_cnt settle with done.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sram.ramaddr = busy ? gen_addr : func_addr;
  assign sram.ramin   = busy ? seq_wdata : func_wdata;
  assign sram.we      = busy ? (run && (op == OP_W)) : func_we;

  assign dbg = '{state: state, elem: elem, op: op, first: gen_first};

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: registered-read 256x8 SRAM model with stuck-at fault hooks.
module tb_mbist_march_ctrl;
  import mbist_pkg::*;

  localparam int W = 28;
  localparam int LAT = 2562;
  localparam int BUSY_CYC = 2561;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] func_addr = '0;
  logic [7:0] func_wdata = '0;
  logic       func_we = 1'b0;
  logic       busy, done, fail;
  logic [7:0] fail_addr, fail_rdata, err_cnt;
  logic [2:0] fail_elem;
  mbist_dbg_t dbg;

  mbist_march_ctrl_if #(.ADDR_W(8), .DATA_W(8)) sram ();

  mbist_march_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .func_addr  (func_addr),
    .func_wdata (func_wdata),
    .func_we    (func_we),
    .sram       (sram),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_rdata (fail_rdata),
    .err_cnt    (err_cnt),
    .dbg        (dbg)
  );

  // clock / SRAM model / counters
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] rd;
  logic [7:0] flt_addr = 8'h00;
  logic [7:0] sa1_mask = 8'h00;
  logic [7:0] sa0_mask = 8'h00;
  int         edge_cnt = 0;
  int         wr_cnt = 0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (sram.we === 1'b1) begin
      mem[sram.ramaddr] <= sram.ramin;
      wr_cnt <= wr_cnt + 1;
    end
    rd = mem[sram.ramaddr];
    if (sram.ramaddr == flt_addr) rd = (rd | sa1_mask) & ~sa0_mask;
    sram.ramout <= rd;
  end

  int errors = 0;
  int checks = 0;
  int k_edge = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] got_v;

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 k_edge = edge_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int repulse_at, output int lat, output int bcnt, output bit ok);
    ok = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      start = (i == repulse_at);
      if (busy) bcnt++;
      if (done) begin
        lat = edge_cnt - k_edge;
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic set_fault(input logic [7:0] a, input logic [7:0] s1, input logic [7:0] s0);
    flt_addr = a;
    sa1_mask = s1;
    sa0_mask = s0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    func_addr = 8'h21; func_wdata = 8'h9E; func_we = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b exp 0", done); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %0b exp 0", fail); end
    checks++; if ({fail_addr, fail_elem, fail_rdata} !== 19'h0) begin
      errors++; $display("FAIL reset_fail_info: got %0h/%0h/%0h exp 0/0/0", fail_addr, fail_elem, fail_rdata);
    end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %0h exp 0", err_cnt); end
    checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg.state, IDLE); end
    checks++; if ({sram.ramaddr, sram.ramin, sram.we} !== {8'h21, 8'h9E, 1'b0}) begin
      errors++; $display("FAIL reset_ports: got %0h/%0h/%0b exp 21/9e/0", sram.ramaddr, sram.ramin, sram.we);
    end
  endtask

  task automatic test_fault_free();
    int lat, bcnt;
    bit ok;
    set_fault(8'h00, 8'h00, 8'h00);
    exp_q.push_back({1'b0, 8'h00, 3'd0, 8'h00, 8'd0});
    wr_cnt = 0;
    pulse_start();
    wait_done(-1, lat, bcnt, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ff_timeout: got no done exp done within 4000"); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL ff_latency: got %0d exp %0d", lat, LAT); end
    checks++; if (bcnt != BUSY_CYC) begin errors++; $display("FAIL ff_busy_cycles: got %0d exp %0d", bcnt, BUSY_CYC); end
    checks++; if (wr_cnt != 1280) begin errors++; $display("FAIL ff_writes: got %0d exp 1280", wr_cnt); end
    exp_v = exp_q.pop_front();
    got_v = {fail, fail_addr, fail_elem, fail_rdata, err_cnt};
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL ff_result: got %0h exp %0h", got_v, exp_v); end
  endtask

  task automatic test_stuck_at_1();
    int lat, bcnt;
    bit ok;
    set_fault(8'h5A, 8'h08, 8'h00);
    exp_q.push_back({1'b1, 8'h5A, 3'd1, 8'h08, 8'd3});
    pulse_start();
    wait_done(-1, lat, bcnt, ok);
    checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL sa1_latency: got %0d exp %0d", lat, LAT); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sa1_done: got %0b exp 1", done); end
    exp_v = exp_q.pop_front();
    got_v = {fail, fail_addr, fail_elem, fail_rdata, err_cnt};
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL sa1_result: got %0h exp %0h", got_v, exp_v); end
  endtask

  task automatic test_stuck_at_0();
    int lat, bcnt;
    bit ok;
    set_fault(8'hFF, 8'h00, 8'h80);
    exp_q.push_back({1'b1, 8'hFF, 3'd2, 8'h7F, 8'd2});
    pulse_start();
    wait_done(-1, lat, bcnt, ok);
    checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL sa0_latency: got %0d exp %0d", lat, LAT); end
    exp_v = exp_q.pop_front();
    got_v = {fail, fail_addr, fail_elem, fail_rdata, err_cnt};
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL sa0_result: got %0h exp %0h", got_v, exp_v); end
  endtask

  task automatic test_rst_mid_run();
    int lat, bcnt;
    bit ok;
    logic [7:0] a, d;
    set_fault(8'h5A, 8'h08, 8'h00);
    pulse_start();
    repeat (999) @(posedge clk);
    @(negedge clk);
    checks++; if (err_cnt == 8'd0) begin errors++; $display("FAIL mid_err_seen: got %0d exp nonzero", err_cnt); end
    a = 8'($urandom_range(0, 255));
    d = 8'($urandom_range(0, 255));
    rst = 1'b1;
    func_addr = a; func_wdata = d; func_we = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({busy, done, fail} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags: got %0b exp 000", {busy, done, fail}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_err_cnt: got %0d exp 0", err_cnt); end
    checks++; if ({sram.ramaddr, sram.ramin, sram.we} !== {a, d, 1'b0}) begin
      errors++; $display("FAIL mid_rst_ports: got %0h/%0h/%0b exp %0h/%0h/0", sram.ramaddr, sram.ramin, sram.we, a, d);
    end
    @(negedge clk);
    rst = 1'b0;
    set_fault(8'h00, 8'h00, 8'h00);
    exp_q.push_back({1'b0, 8'h00, 3'd0, 8'h00, 8'd0});
    pulse_start();
    wait_done(-1, lat, bcnt, ok);
    checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL mid_rerun_latency: got %0d exp %0d", lat, LAT); end
    checks++; if (bcnt != BUSY_CYC) begin errors++; $display("FAIL mid_rerun_busy: got %0d exp %0d", bcnt, BUSY_CYC); end
    exp_v = exp_q.pop_front();
    got_v = {fail, fail_addr, fail_elem, fail_rdata, err_cnt};
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL mid_rerun_result: got %0h exp %0h", got_v, exp_v); end
  endtask

  task automatic test_start_ignored();
    int lat, bcnt;
    bit ok;
    exp_q.push_back({1'b0, 8'h00, 3'd0, 8'h00, 8'd0});
    pulse_start();
    wait_done(499, lat, bcnt, ok);
    checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL repulse_latency: got %0d exp %0d", lat, LAT); end
    checks++; if (bcnt != BUSY_CYC) begin errors++; $display("FAIL repulse_busy: got %0d exp %0d", bcnt, BUSY_CYC); end
    exp_v = exp_q.pop_front();
    got_v = {fail, fail_addr, fail_elem, fail_rdata, err_cnt};
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL repulse_result: got %0h exp %0h", got_v, exp_v); end
  endtask

  task automatic test_passthrough();
    logic [7:0] a, d;
    logic       w;
    @(negedge clk);
    func_we = 1'b1; func_addr = 8'h33; func_wdata = 8'hC4;
    @(negedge clk);
    func_we = 1'b0; func_addr = 8'h33;
    @(posedge clk);
    #1;
    checks++; if (sram.ramout !== 8'hC4) begin errors++; $display("FAIL pass_readback: got %0h exp c4", sram.ramout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy: got %0b exp 0", busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      w = 1'($urandom_range(0, 1));
      func_addr = a; func_wdata = d; func_we = w;
      #1;
      checks++; if ({sram.ramaddr, sram.ramin, sram.we} !== {a, d, w}) begin
        errors++; $display("FAIL pass_mux: got %0h/%0h/%0b exp %0h/%0h/%0b", sram.ramaddr, sram.ramin, sram.we, a, d, w);
      end
    end
    @(negedge clk);
    func_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_fault_free();
    test_stuck_at_1();
    test_stuck_at_0();
    test_rst_mid_run();
    test_start_ignored();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d exp 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
